// File: rtl/cdc_xfer_arb_ctrl.sv
// Round-robin arbiter that hands one word at a time to another clock domain
// over a 4-phase req/ack handshake with per-phase timeout recovery.
module cdc_xfer_arb_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 16,
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       xfer_req,
  output logic [DATA_W-1:0]          xfer_data,
  input  logic                       xfer_ack_sync,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err
);

  localparam int          ID_W       = $clog2(NUM_REQ);
  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_REQ_HI = 3'd2,
    ST_REQ_LO = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [DATA_W-1:0] xfer_data_q, xfer_data_d;
  logic              xfer_req_q, xfer_req_d;
  logic              timeout_err_q, timeout_err_d;

  logic [ID_W-1:0]   winner_s;
  logic [ID_W-1:0]   idx_s;
  logic              any_valid_s;
  logic              accept_s;
  logic [DATA_W-1:0] data_arr_s [NUM_REQ];

  // Unpack the flat requester data bus into per-requester words.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr_s[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin pick: scanning from the far end down means the candidate
  // closest to the priority pointer is the last (winning) assignment.
  always_comb begin
    int sum;
    sum         = 0;
    idx_s       = '0;
    winner_s    = '0;
    any_valid_s = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum         = int'(ptr_q) + k;
      idx_s       = (sum >= NUM_REQ) ? ID_W'(sum - NUM_REQ) : ID_W'(sum);
      winner_s    = req_valid[idx_s] ? idx_s : winner_s;
      any_valid_s = any_valid_s | req_valid[idx_s];
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 16'd0;
      ptr_q         <= '0;
      grant_id_q    <= '0;
      xfer_data_q   <= '0;
      xfer_req_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ptr_q         <= ptr_d;
      grant_id_q    <= grant_id_d;
      xfer_data_q   <= xfer_data_d;
      xfer_req_q    <= xfer_req_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state logic; a stale high ack blocks new grants in IDLE.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ptr_d         = ptr_q;
    grant_id_d    = grant_id_q;
    xfer_data_d   = xfer_data_q;
    timeout_err_d = 1'b0;
    accept_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid_s && !xfer_ack_sync) begin
          accept_s    = 1'b1;
          grant_id_d  = winner_s;
          xfer_data_d = data_arr_s[winner_s];
          ptr_d       = (winner_s == ID_W'(NUM_REQ - 1)) ? '0 : winner_s + ID_W'(1);
          cnt_d       = 16'd0;
          state_d     = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = 16'd0;
          state_d = ST_REQ_HI;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_REQ_HI: begin
        if (xfer_ack_sync) begin
          cnt_d   = 16'd0;
          state_d = ST_REQ_LO;
        end else if (cnt_q == TMO_LAST) begin
          timeout_err_d = 1'b1;
          cnt_d         = 16'd0;
          state_d       = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_REQ_LO: begin
        if (!xfer_ack_sync) begin
          cnt_d   = 16'd0;
          state_d = ST_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          timeout_err_d = 1'b1;
          cnt_d         = 16'd0;
          state_d       = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DRAIN: begin
        if (!xfer_ack_sync) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        cnt_d   = 16'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs; xfer_req is registered off the next state so it never glitches.
  always_comb begin
    xfer_req_d  = (state_d == ST_REQ_HI);
    req_ready   = accept_s ? (NUM_REQ'(1) << winner_s) : '0;
    busy        = (state_q != ST_IDLE);
    xfer_req    = xfer_req_q;
    xfer_data   = xfer_data_q;
    grant_id    = grant_id_q;
    timeout_err = timeout_err_q;
  end

endmodule
